// File: rtl/mul_seq_16bit.sv
// mul_seq_16bit: iterative 16x16 -> 32 unsigned radix-2 shift-add multiplier.
// start/busy/done handshake; one 17-bit add per cycle over 16 RUN cycles.
// Optional build macro MUL_EARLY_TERM_EN: ends RUN as soon as the unconsumed
// multiplier bits are all zero, realigning the partial product on exit.
module mul_seq_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_mcand;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [4:0]  r_cnt;

  logic [16:0] w_sum;
  logic [16:0] w_add;
  logic [15:0] w_hi_n;
  logic [15:0] w_lo_n;
  logic [4:0]  w_cnt_n;
  logic        w_last;
  logic        w_finish;
  logic        w_accept;

`ifdef MUL_EARLY_TERM_EN
  logic [15:0] w_rem_mask;
  logic        w_early;
  logic [31:0] w_align;
`endif

  // One shift-add step: conditional add of the multiplicand, carry kept,
  // then the 33-bit {c,s,lo} is shifted right by one into {hi,lo}.
  always_comb begin
    w_sum   = {1'b0, r_hi} + {1'b0, r_mcand};
    w_add   = r_lo[0] ? w_sum : {1'b0, r_hi};
    w_hi_n  = w_add[16:1];
    w_lo_n  = {w_add[0], r_lo[15:1]};
    w_cnt_n = r_cnt + 5'd1;
    w_last  = (w_cnt_n == 5'd16);
  end

`ifdef MUL_EARLY_TERM_EN
  // After cnt steps, {hi,lo} = (partial product << (16-cnt)) | (b >> cnt);
  // once the remaining multiplier bits are zero the shifted-down value is final.
  always_comb begin
    w_rem_mask = 16'hFFFF >> r_cnt;
    w_early    = ((r_lo & w_rem_mask) == '0);
    w_align    = {r_hi, r_lo} >> (5'd16 - r_cnt);
    w_finish   = w_last | w_early;
  end
`else
  // Fixed 16-step run: finish only on the last iteration.
  always_comb begin
    w_finish = w_last;
  end
`endif

  // New operation accepted whenever not running and start is asserted.
  always_comb begin
    w_accept = (r_state != S_RUN) && start;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_finish) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // Datapath: operand latch on accept, iteration in RUN, product load on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
`ifdef MUL_EARLY_TERM_EN
      if (w_early) begin
        product <= w_align;
      end else begin
        r_hi  <= w_hi_n;
        r_lo  <= w_lo_n;
        r_cnt <= w_cnt_n;
        if (w_last) product <= {w_hi_n, w_lo_n};
      end
`else
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= w_cnt_n;
      if (w_last) product <= {w_hi_n, w_lo_n};
`endif
    end
  end

endmodule

// File: doc/mul_seq_16bit.md
# mul_seq_16bit

Iterative 16x16 unsigned multiplier for the unpipelined processor datapath, downstream of the 16-bit carry-lookahead adder. It consumes one 16-bit add with carry-out per cycle in a radix-2 shift-add loop and produces a 32-bit product. A start/busy/done handshake lets the control unit stall the pipeline-free datapath until the product is valid.

## Interface

- Parameters: none (width fixed at 16x16 -> 32).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  16  multiplicand; latched when start is accepted.
- b  input  16  multiplier; latched when start is accepted.
- busy  output  1  high while an operation is in the RUN state.
- done  output  1  one-cycle pulse; product valid that cycle.
- product  output  32  result register; holds last result until the next completion.

## Operation

- States: IDLE, RUN, DONE. Reset -> IDLE.
- Internal regs: mcand[15:0], hi[15:0], lo[15:0], cnt[4:0].
- Accept: in IDLE or DONE with start=1 -> mcand<=a, hi<=0, lo<=b, cnt<=0, go RUN.
- In DONE with start=0 -> IDLE. In RUN, start is ignored; a/b are not re-latched.
- RUN iteration: {c,s} = lo[0] ? hi+mcand (17-bit, carry kept) : {1'b0,hi}; {hi,lo} <= {c,s,lo[15:1]}; cnt<=cnt+1.
- After iteration with cnt reaching 16 -> DONE; product<={hi,lo} of that update.
- product loads only on the RUN->DONE transition; unchanged in IDLE, RUN, and reset-free DONE.
- Arithmetic is unsigned modulo 2^32; overflow is impossible (max 0xFFFE0001).

## Timing

- Reset values: busy=0, done=0, product=32'h0, state IDLE, cnt=0.
- Start accepted at edge E0 -> busy=1 after E0.
- Iterations on edges E1..E16; after E16: busy=0, done=1, product valid.
- done is high for exactly one cycle (the DONE state); after E17 done=0 unless a new start was accepted at E17, in which case busy=1 after E17.
- Back-to-back: start held high in DONE cycle -> next operation begins with zero idle cycles; throughput one product per 17 cycles.
- busy and done are never high together.
- Reset mid-RUN: next edge -> IDLE, busy=0, no done pulse, product keeps its reset value 0.
- Start and rst high together: rst wins.

## Configuration

- Macro MUL_EARLY_TERM_EN.
- Defined: at the start of each RUN cycle, if the unconsumed multiplier bits (lo[15-cnt:0]) are all zero, that cycle performs no add; it performs the final alignment product<={hi,lo}>>(16-cnt) and goes to DONE. Latency from accept to done = min(16, msb_index(b)+2); b=0 -> 1 cycle.
- Not defined: fixed 16-cycle latency regardless of operands; no alignment shifter synthesized.
- Results are bit-identical in both builds; only latency differs.

## Test plan

- a=3, b=5, start 1 cycle -> busy for 16 cycles, done pulse with product=32'h0000000F (no macro); done 4 cycles after accept with macro.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001 after 16 cycles in both builds.
- Start held high through DONE: ops (7x9) then (16'h1234x16'h0010) -> products 32'h3F then 32'h00012340, second busy rises the cycle after first done, no idle gap.
- Start pulsed at cycle 5 of RUN with different a/b -> ignored; first product unaffected; no extra done.
- rst asserted at RUN cycle 8 -> next cycle busy=0, done=0, product=0; no later done pulse.
- With MUL_EARLY_TERM_EN: b=0, a=16'hABCD -> done 1 cycle after accept, product=0; b=1, a=16'hABCD -> done after 2 cycles, product=32'h0000ABCD.
